// File: rtl/uart_switch_guard_if.sv
// Signal bundle between the UART switch guard and its surroundings:
// the raw button and UART lines going in, the steer level and pending LED coming out.
interface uart_switch_guard_if;
  logic btn;
  logic rx_pc;
  logic rx_esp_master;
  logic rx_esp_sim;
  logic select;
  logic pending;

  modport master (
    output btn, rx_pc, rx_esp_master, rx_esp_sim,
    input  select, pending
  );

  modport slave (
    input  btn, rx_pc, rx_esp_master, rx_esp_sim,
    output select, pending
  );
endinterface

// File: rtl/uart_switch_guard.sv
// Steers the PC UART between ESP master and ESP sim. A debounced button press
// requests a switch, the switch waits for all lines to idle, then a lockout follows.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_ACTIVE  | steady; a press requests a switch
//   ST_PENDING | switch requested, waiting for line idle; a press cancels
//   ST_SETTLE  | just switched; presses ignored until lines idle again
module uart_switch_guard #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int DEBOUNCE_MS  = 20,
  parameter int IDLE_BITS    = 12,
  parameter bit SELECT_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  uart_switch_guard_if.slave bus
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int IDLE_CYC = BIT_CYC * IDLE_BITS;
  localparam int DB_W     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int IDLE_W   = $clog2(IDLE_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(IDLE_CYC);

  if (BIT_CYC < 4) begin : g_bit_cyc_chk
    $error("uart_switch_guard: BIT_CYC = CLK_HZ/BAUD must be at least 4");
  end

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } state_t;

  logic              r_btn_s1, r_btn_s2;
  logic [2:0]        r_rx_s1, r_rx_s2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_db_level, r_db_prev, r_press;
  logic [IDLE_W-1:0] r_idle_cnt;
  state_t            r_state;
  logic              r_select, r_pending;

  state_t            w_state_nxt;
  logic              w_select_nxt, w_pending_nxt, w_idle_clr;
  logic              w_all_high, w_line_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_rx_s1  <= 3'b111;
      r_rx_s2  <= 3'b111;
    end else begin
      r_btn_s1 <= bus.btn;
      r_btn_s2 <= r_btn_s1;
      r_rx_s1  <= {bus.rx_pc, bus.rx_esp_master, bus.rx_esp_sim};
      r_rx_s2  <= r_rx_s1;
    end
  end

  // The press pulse comes from the registered level, one cycle after the flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_db_prev <= r_db_level;
      r_press   <= r_db_level & ~r_db_prev;
      if (r_btn_s2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt   <= '0;
        r_db_level <= ~r_db_level;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_all_high  = &r_rx_s2;
  assign w_line_idle = (r_idle_cnt == IDLE_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (w_idle_clr || !w_all_high) begin
      r_idle_cnt <= '0;
    end else if (!w_line_idle) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_ACTIVE;
      r_select  <= SELECT_RESET;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_select  <= w_select_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // A press in PENDING is checked before line_idle so a cancel always wins.
  always_comb begin
    w_state_nxt   = r_state;
    w_select_nxt  = r_select;
    w_pending_nxt = r_pending;
    w_idle_clr    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (r_press) begin
          w_state_nxt   = ST_PENDING;
          w_pending_nxt = 1'b1;
        end
      end
      ST_PENDING: begin
        if (r_press) begin
          w_state_nxt   = ST_ACTIVE;
          w_pending_nxt = 1'b0;
        end else if (w_line_idle) begin
          w_state_nxt   = ST_SETTLE;
          w_select_nxt  = ~r_select;
          w_pending_nxt = 1'b0;
          w_idle_clr    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_line_idle) begin
          w_state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        w_state_nxt   = ST_ACTIVE;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  assign bus.select  = r_select;
  assign bus.pending = r_pending;

endmodule

// File: tb/tb_uart_switch_guard.sv
// Bench for uart_switch_guard: directed scenarios plus a random phase, checked every
// cycle against a history-based model of debounce, idle window and switch rules.
module tb_uart_switch_guard;

  localparam int CLK_HZ      = 100000;
  localparam int BAUD        = 10000;
  localparam int DEBOUNCE_MS = 1;
  localparam int IDLE_BITS   = 2;
  localparam bit SEL_RST     = 1'b1;
  localparam int DB_CYC      = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int IDLE_CYC    = (CLK_HZ / BAUD) * IDLE_BITS;

  localparam int M_ACT  = 0;
  localparam int M_PEND = 1;
  localparam int M_SET  = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  uart_switch_guard_if u_if ();

  uart_switch_guard #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .IDLE_BITS   (IDLE_BITS),
    .SELECT_RESET(SEL_RST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: q_btn[k] / q_idle[k] are the synchronized values the logic sees at edge k.
  bit q_btn[$];
  bit q_idle[$];
  int m_press_at[$];
  int m_n;
  int m_last_clr;
  int m_mode;
  bit m_level;
  bit m_sel;
  bit m_pend;

  task automatic model_reset();
    q_btn.delete();
    q_idle.delete();
    m_press_at.delete();
    q_btn.push_back(1'b0);
    q_btn.push_back(1'b0);
    q_idle.push_back(1'b1);
    q_idle.push_back(1'b1);
    m_n        = 0;
    m_last_clr = -1;
    m_mode     = M_ACT;
    m_level    = 1'b0;
    m_sel      = SEL_RST;
    m_pend     = 1'b0;
  endtask

  task automatic model_step();
    bit flip;
    bit press;
    bit idle;
    bit sw;
    q_btn.push_back(u_if.btn);
    q_idle.push_back(u_if.rx_pc & u_if.rx_esp_master & u_if.rx_esp_sim);
    // level flips once the button has sat at the other value for DB_CYC edges
    flip = (m_n >= DB_CYC - 1);
    for (int j = 0; j < DB_CYC && flip; j++)
      if (q_btn[m_n - j] == m_level) flip = 1'b0;
    if (flip) begin
      m_level = ~m_level;
      if (m_level) m_press_at.push_back(m_n + 2);
    end
    press = 1'b0;
    if (m_press_at.size() > 0 && m_press_at[0] == m_n) begin
      press = 1'b1;
      void'(m_press_at.pop_front());
    end
    idle = ((m_n - 1) - m_last_clr) >= IDLE_CYC;
    sw   = 1'b0;
    if (m_mode == M_ACT) begin
      if (press) begin m_mode = M_PEND; m_pend = 1'b1; end
    end else if (m_mode == M_PEND) begin
      if (press) begin
        m_mode = M_ACT; m_pend = 1'b0;
      end else if (idle) begin
        m_mode = M_SET; m_pend = 1'b0; m_sel = ~m_sel; sw = 1'b1;
      end
    end else begin
      if (idle) m_mode = M_ACT;
    end
    if (!q_idle[m_n] || sw) m_last_clr = m_n;
    m_n++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("select", u_if.select, m_sel);
    chk("pending", u_if.pending, m_pend);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_select", u_if.select, SEL_RST);
      chk("rst_pending", u_if.pending, 1'b0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic mid_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk({tag, "_async_select"}, u_if.select, SEL_RST);
    chk({tag, "_async_pending"}, u_if.pending, 1'b0);
    hold_reset();
  endtask

  task automatic set_lines(input bit p, input bit m, input bit s);
    u_if.rx_pc         = p;
    u_if.rx_esp_master = m;
    u_if.rx_esp_sim    = s;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    u_if.btn = 1'b0;
    set_lines(1, 1, 1);
    hold_reset();

    // 1: idle after reset, asynchronous reset mid-cycle
    repeat (50) cyc();
    chk("t1_select", u_if.select, 1'b1);
    chk("t1_pending", u_if.pending, 1'b0);
    mid_reset("t1");

    // 2: bounce shorter than the debounce time
    for (int i = 0; i < 300; i++) begin
      u_if.btn = ((i / 30) % 2 == 0);
      cyc();
    end
    u_if.btn = 1'b0;
    repeat (150) cyc();
    chk("t2_pending", u_if.pending, 1'b0);
    chk("t2_select", u_if.select, 1'b1);

    // 3: clean press with idle lines, then a press during SETTLE
    repeat (50) cyc();
    u_if.btn = 1'b1;
    for (int i = 0; i < 103; i++) begin
      cyc();
      chk("t3_wait_pending", u_if.pending, 1'b0);
    end
    cyc();
    chk("t3_pending_on", u_if.pending, 1'b1);
    chk("t3_select_hold", u_if.select, 1'b1);
    cyc();
    chk("t3_pending_off", u_if.pending, 1'b0);
    chk("t3_select_toggle", u_if.select, 1'b0);
    u_if.rx_pc = 1'b0;
    repeat (95) cyc();
    u_if.btn = 1'b0;
    repeat (150) cyc();
    u_if.btn = 1'b1;
    repeat (150) cyc();
    chk("t3_settle_pending", u_if.pending, 1'b0);
    u_if.btn = 1'b0;
    u_if.rx_pc = 1'b1;
    repeat (150) cyc();
    chk("t3_final_select", u_if.select, 1'b0);
    chk("t3_final_pending", u_if.pending, 1'b0);

    // 4: press during traffic on rx_esp_sim
    for (int i = 0; i < 150; i++) begin
      u_if.btn = 1'b1;
      u_if.rx_esp_sim = ((i % 15) >= 10);
      cyc();
      if (i >= 103) chk("t4_pending_traffic", u_if.pending, 1'b1);
    end
    u_if.rx_esp_sim = 1'b1;
    for (int j = 0; j < 17; j++) begin
      cyc();
      chk("t4_select_wait", u_if.select, 1'b0);
    end
    cyc();
    chk("t4_select_toggle", u_if.select, 1'b1);
    chk("t4_pending_off", u_if.pending, 1'b0);
    u_if.btn = 1'b0;
    repeat (150) cyc();

    // 5: cancel while a line is held low, then reset mid-PENDING
    u_if.rx_pc = 1'b0;
    u_if.btn = 1'b1;
    repeat (110) cyc();
    chk("t5_pending_on", u_if.pending, 1'b1);
    u_if.btn = 1'b0;
    repeat (150) cyc();
    chk("t5_release_nop", u_if.pending, 1'b1);
    u_if.btn = 1'b1;
    repeat (110) cyc();
    chk("t5_cancel_pending", u_if.pending, 1'b0);
    u_if.rx_pc = 1'b1;
    repeat (50) cyc();
    chk("t5_cancel_select", u_if.select, 1'b1);
    u_if.btn = 1'b0;
    repeat (150) cyc();
    u_if.rx_pc = 1'b0;
    u_if.btn = 1'b1;
    repeat (110) cyc();
    chk("t5_pre_reset_pending", u_if.pending, 1'b1);
    mid_reset("t5");
    u_if.btn = 1'b0;
    u_if.rx_pc = 1'b1;
    repeat (50) cyc();

    // 6: cancel press lands on the same edge that line_idle rises
    u_if.rx_pc = 1'b0;
    u_if.btn = 1'b1;
    repeat (110) cyc();
    u_if.btn = 1'b0;
    repeat (150) cyc();
    chk("t6_pending_on", u_if.pending, 1'b1);
    for (int i = 0; i < 130; i++) begin
      u_if.btn = 1'b1;
      u_if.rx_pc = (i > 80);
      cyc();
      if (i == 102) chk("t6_pending_before", u_if.pending, 1'b1);
      if (i == 103) begin
        chk("t6_cancel_pending", u_if.pending, 1'b0);
        chk("t6_cancel_select", u_if.select, 1'b1);
      end
    end
    u_if.btn = 1'b0;
    repeat (150) cyc();
    chk("t6_final_select", u_if.select, 1'b1);

    // 7: switch, then reset mid-SETTLE
    u_if.btn = 1'b1;
    repeat (105) cyc();
    u_if.rx_esp_master = 1'b0;
    repeat (5) cyc();
    chk("t7_pre_reset_select", u_if.select, 1'b0);
    mid_reset("t7");
    u_if.btn = 1'b0;
    u_if.rx_esp_master = 1'b1;
    repeat (150) cyc();

    // random phase: button segments of random length, lines quiet or busy
    for (int seg = 0; seg < 25; seg++) begin
      int  dur;
      bit  busy;
      dur  = $urandom_range(20, 250);
      busy = ($urandom_range(0, 9) < 4);
      u_if.btn = $urandom_range(0, 1);
      for (int k = 0; k < dur; k++) begin
        if (busy) set_lines($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                            $urandom_range(0, 7) != 0);
        else      set_lines(1, 1, 1);
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
